// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the instruction-fetch sequencer:
//                FSM state encodings, output FIFO depth, default reset PC
//                and the issue-credit helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam int FIFO_DEPTH       = 2;
  localparam int COUNT_W          = 2;  // holds 0..FIFO_DEPTH
  localparam int DEFAULT_RESET_PC = 0;

  // A new read may issue only if every word already owed to the FIFO
  // (buffered + in flight, minus the one leaving this cycle) still leaves
  // a free slot for the word this issue will return.
  function automatic logic has_credit(input logic [COUNT_W-1:0] count,
                                      input logic               inflight,
                                      input logic               pop);
    logic [COUNT_W:0] committed;
    committed = {1'b0, count} + {{COUNT_W{1'b0}}, inflight}
              - {{COUNT_W{1'b0}}, pop};
    return committed < (COUNT_W + 1)'(FIFO_DEPTH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
// ============================================================================
//  Module      : fetch_skid_fifo
//  Description : Two-entry FIFO of {instruction, pc} between the memory
//                response path and the decode handshake.
//  Ports       : clk/rst_n   clock, asynchronous active-low reset
//                push/push_* write a returned word
//                pop         remove head entry
//                flush       discard all entries (wins over push/pop)
//                head_*      head entry, empty, count
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [31:0]        push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [31:0]        head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  logic [31:0]       mem_instr [0:FIFO_DEPTH-1];
  logic [ADDR_W-1:0] mem_pc    [0:FIFO_DEPTH-1];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_pop;
  logic              do_push;
  logic              full;

  assign empty      = (count == '0);
  assign full       = (count == COUNT_W'(FIFO_DEPTH));
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_instr[wr_ptr] <= push_instr;
        mem_pc[wr_ptr]    <= push_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + COUNT_W'(do_push) - COUNT_W'(do_pop);
    end
  end

  // The upstream credit check makes a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      a_no_overflow: assert (!(push && full && !pop));
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch controller. Owns the PC, issues reads to
//                a 1-cycle-latency instruction memory, buffers returned words
//                and hands them to decode over valid/ready. Handles redirects
//                and halts on an out-of-range fetch.
//  Ports       : Clk, Reset_n            clock, async active-low reset
//                Start, Stop             begin fetching / suppress issues
//                RedirectValid/PC        PC change from execute
//                MemAddress/MemReadData  instruction memory interface
//                InstrValid/Ready/Instr/InstrPC  decode handshake
//                Fault/FaultPC           sticky out-of-range indication
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 MEM_DEPTH = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stop,
  input  logic              RedirectValid,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic [ADDR_W-1:0] MemAddress,
  input  logic [31:0]       MemReadData,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              Fault,
  output logic [ADDR_W-1:0] FaultPC
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_DEPTH);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic               inflight;
  logic [ADDR_W-1:0]  tag_pc;
  logic [COUNT_W-1:0] count;
  logic               empty;
  logic               pop;
  logic               redirect;
  logic               fetch_ok;
  logic               issue;
  logic               fault_now;
  logic               push;

  assign MemAddress = pc;
  assign InstrValid = !empty;
  assign pop        = InstrValid && InstrReady;

  // Redirects are honoured in IDLE and RUN only; HALT is terminal.
  assign redirect   = RedirectValid && (state != ST_HALT);
  assign fetch_ok   = (state == ST_RUN) && !redirect && !Stop;
  assign issue      = fetch_ok && (pc < MEM_LIMIT) && has_credit(count, inflight, pop);
  assign fault_now  = fetch_ok && (pc >= MEM_LIMIT);
  // A redirect squashes the word still in flight.
  assign push       = inflight && !redirect;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      tag_pc   <= '0;
      Fault    <= 1'b0;
      FaultPC  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_pc <= pc;
        pc     <= pc + ADDR_W'(1);
      end
      if (redirect) begin
        pc <= RedirectPC;
      end
      case (state)
        ST_IDLE: begin
          if (Start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (fault_now) begin
            state   <= ST_HALT;
            Fault   <= 1'b1;
            FaultPC <= pc;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_skid_fifo #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .push       (push),
    .push_instr (MemReadData),
    .push_pc    (tag_pc),
    .pop        (pop),
    .flush      (redirect),
    .head_instr (Instr),
    .head_pc    (InstrPC),
    .empty      (empty),
    .count      (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer. The
//                memory model returns 32'h1000_0000 + address one edge after
//                the address is presented.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int vectors;
  int miscompares;

  fetch_sequencer #(
    .ADDR_W    (32),
    .MEM_DEPTH (32),
    .RESET_PC  (32'd0)
  ) dut (
    .Clk           (clk),
    .Reset_n       (reset_n),
    .Start         (start),
    .Stop          (stop),
    .RedirectValid (redirect_valid),
    .RedirectPC    (redirect_pc),
    .MemAddress    (mem_address),
    .MemReadData   (mem_read_data),
    .InstrValid    (instr_valid),
    .InstrReady    (instr_ready),
    .Instr         (instr),
    .InstrPC       (instr_pc),
    .Fault         (fault),
    .FaultPC       (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: one edge of read latency.
  always_ff @(posedge clk) begin
    mem_read_data <= 32'h1000_0000 + mem_address;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect a valid head instruction from address a.
  task automatic check_head(input string tag, input logic [31:0] a);
    check1(tag, instr_valid, 1'b1);
    check32(tag, instr_pc, a);
    check32(tag, instr, 32'h1000_0000 + a);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    do_reset();

    // Reset state
    check1 ("rst_valid",   instr_valid, 1'b0);
    check32("rst_instr",   instr,       32'h0);
    check32("rst_instrpc", instr_pc,    32'h0);
    check1 ("rst_fault",   fault,       1'b0);
    check32("rst_faultpc", fault_pc,    32'h0);
    check32("rst_addr",    mem_address, 32'h0);

    // 1. Start and stream with InstrReady=1
    start = 1'b1; instr_ready = 1'b1;
    step();                                   // edge E
    start = 1'b0;
    check1("t1_e0_valid", instr_valid, 1'b0);
    step();                                   // E+1
    check1 ("t1_e1_valid", instr_valid, 1'b0);
    check32("t1_e1_addr",  mem_address, 32'd1);
    step();                                   // E+2
    check_head("t1_i0", 32'd0);
    step();
    check_head("t1_i1", 32'd1);
    step();
    check_head("t1_i2", 32'd2);

    // 2. Backpressure
    do_reset();
    start = 1'b1;
    step();                                   // E
    start = 1'b0;
    step();                                   // E+1
    step();                                   // E+2: first valid
    for (int i = 0; i < 5; i++) begin
      check_head("t2_hold", 32'd0);
      check32("t2_addr_stall", mem_address, 32'd2);
      if (i < 4) step();
    end
    instr_ready = 1'b1;
    step();
    check_head("t2_r1", 32'd1);
    step();
    check_head("t2_r2", 32'd2);
    step();
    check_head("t2_r3", 32'd3);

    // 3. Redirect to 16 with 4 in flight and 5 pending
    redirect_valid = 1'b1; redirect_pc = 32'd16;
    step();                                   // R
    redirect_valid = 1'b0;
    check1 ("t3_r0_valid", instr_valid, 1'b0);
    check32("t3_r0_addr",  mem_address, 32'd16);
    step();                                   // R+1
    check1("t3_r1_valid", instr_valid, 1'b0);
    step();                                   // R+2
    check_head("t3_i16", 32'd16);
    step();
    check_head("t3_i17", 32'd17);
    step();
    check_head("t3_i18", 32'd18);

    // 4. Redirect to 30, run off the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'd30;
    step();
    redirect_valid = 1'b0;
    check1("t4_r0_valid", instr_valid, 1'b0);
    step();
    check1("t4_r1_valid", instr_valid, 1'b0);
    check1("t4_r1_fault", fault,       1'b0);
    step();
    check_head("t4_i30", 32'd30);
    check1("t4_nofault_yet", fault, 1'b0);
    step();
    check_head("t4_i31", 32'd31);
    check1 ("t4_fault",   fault,    1'b1);
    check32("t4_faultpc", fault_pc, 32'd32);
    check32("t4_state",   32'(dut.state), 32'(ST_HALT));
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    step();
    redirect_valid = 1'b0;
    check1 ("t4_drained",   instr_valid, 1'b0);
    check32("t4_ign_redir", mem_address, 32'd32);
    step();
    step();
    check1 ("t4_still_empty", instr_valid, 1'b0);
    check1 ("t4_sticky",      fault,       1'b1);
    check32("t4_state_held",  32'(dut.state), 32'(ST_HALT));

    // 5. Stop mid-run
    do_reset();
    check1("t5_fault_cleared", fault, 1'b0);
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_head("t5_i0", 32'd0);
    step();
    check_head("t5_i1", 32'd1);
    stop = 1'b1;
    step();
    check_head("t5_inflight", 32'd2);
    check32("t5_addr_s1", mem_address, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check1 ("t5_stop_empty", instr_valid, 1'b0);
      check32("t5_stop_addr",  mem_address, 32'd3);
    end
    stop = 1'b0;
    step();
    check1 ("t5_resume_gap",  instr_valid, 1'b0);
    check32("t5_resume_addr", mem_address, 32'd4);
    step();
    check_head("t5_i3", 32'd3);
    step();
    check_head("t5_i4", 32'd4);

    // 6. Asynchronous reset with two words buffered
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();                                   // two words now buffered
    check_head("t6_buffered", 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check1 ("t6_async_valid", instr_valid, 1'b0);
    check1 ("t6_async_fault", fault,       1'b0);
    check32("t6_async_addr",  mem_address, 32'd0);
    check32("t6_async_state", 32'(dut.state), 32'(ST_IDLE));
    step();
    reset_n = 1'b1;
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    check1("t6_e1_valid", instr_valid, 1'b0);
    step();
    check_head("t6_i0", 32'd0);
    step();
    check_head("t6_i1", 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
